// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_pkg
//  Purpose  : Register map, STATUS/CTRL bit positions and FSM state type
//             shared by the SPI master and SPI slave endpoints.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package spi_slave_pkg;

   // CPU register addresses
   localparam logic [3:0] c_ADDR_STATUS   = 4'd0;
   localparam logic [3:0] c_ADDR_DATA_OUT = 4'd1;
   localparam logic [3:0] c_ADDR_DATA_IN  = 4'd2;
   localparam logic [3:0] c_ADDR_CTRL     = 4'd3;

   // STATUS register bit positions
   localparam int c_STAT_BUSY     = 0;
   localparam int c_STAT_RX_VALID = 1;
   localparam int c_STAT_TX_FULL  = 2;
   localparam int c_STAT_OVERRUN  = 3;

   // CTRL register bit positions
   localparam int c_CTRL_CPHA = 0;
   localparam int c_CTRL_CPOL = 1;
   localparam int c_CTRL_EN   = 2;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Multi-stage synchroniser for an asynchronous pin, with
//             single-cycle rise/fall pulses derived from the last two
//             synchronised samples.
//  Ports    : i_clk, i_rst   - system clock, async active-high reset
//             i_din          - asynchronous input pin
//             o_dout         - synchronised level
//             o_rise, o_fall - one-cycle edge pulses (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_din,
   output logic o_dout,
   output logic o_rise,
   output logic o_fall
);

   // Fewer than two stages is not a synchroniser; clamp rather than fail.
   localparam int c_N = (STAGES < 2) ? 2 : STAGES;

   logic [c_N-1:0] r_sync;
   logic           r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= {c_N{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[c_N-2:0], i_din};
         r_prev <= r_sync[c_N-1];
      end
   end

   assign o_dout = r_sync[c_N-1];
   assign o_rise =  r_sync[c_N-1] & ~r_prev;
   assign o_fall = ~r_sync[c_N-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Purpose  : SPI peripheral endpoint. Oversamples SCLK/MOSI/SS in the i_clk
//             domain, shifts bytes MSB-first in all four SPI modes, and
//             exposes a one-byte TX buffer, one-byte RX register and status
//             flags on the CPU register bus.
//  Ports    : i_clk, i_rst            - system clock, async active-high reset
//             i_SCLK, i_MOSI, i_SS    - SPI pins from the external master
//             o_MISO, o_MISO_oe       - SPI data out and its output enable
//             i_en, i_wr, i_addr      - register bus strobe / direction / addr
//             i_data, o_data          - write data / registered read data
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int CLK_FREQ    = 48_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_SCLK,
   input  logic       i_MOSI,
   output logic       o_MISO,
   output logic       o_MISO_oe,
   input  logic       i_SS,
   input  logic       i_en,
   input  logic       i_wr,
   input  logic [3:0] i_addr,
   input  logic [7:0] i_data,
   output logic [7:0] o_data
);

   // SCLK must stay at or below this rate for the oversampler to see every edge.
   localparam int c_unused_max_sclk_hz = CLK_FREQ / 8;

   // ------------------------------------------------------------------
   // Pin synchronisers
   // ------------------------------------------------------------------
   logic w_sclk, w_sclk_rise, w_sclk_fall;
   logic w_ss, w_ss_rise, w_ss_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;
   logic w_unused_pins;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .i_clk (i_clk), .i_rst (i_rst), .i_din (i_SCLK),
      .o_dout(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   // SS is preset high so reset never looks like a select.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .i_clk (i_clk), .i_rst (i_rst), .i_din (i_SS),
      .o_dout(w_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .i_clk (i_clk), .i_rst (i_rst), .i_din (i_MOSI),
      .o_dout(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
   );

   // MOSI is only ever used as a level; SCLK level is only used via its edges.
   assign w_unused_pins = &{1'b0, w_mosi_rise, w_mosi_fall, w_sclk};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t     r_state, w_state_next;
   logic [2:0] r_ctrl;
   logic       r_cpol, r_cpha;          // mode in force for the current select
   logic [7:0] r_tx_buf;
   logic       r_tx_full;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_overrun;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic       r_miso;
   logic       r_miso_oe;
   logic [7:0] r_data;

   logic       w_en, w_busy;
   logic       w_start, w_stop;
   logic       w_act, w_lead, w_trail, w_sample, w_drive;
   logic       w_byte_done;
   logic [7:0] w_shift_in, w_reload_byte;
   logic       w_rd, w_wr;
   logic       w_wr_dout, w_wr_stat, w_wr_ctrl, w_rd_din;
   logic [7:0] w_rd_data;

   assign w_en   = r_ctrl[c_CTRL_EN];
   assign w_busy = w_en & ~w_ss;

   // ------------------------------------------------------------------
   // FSM next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_stop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_en && w_ss_fall) begin
               w_state_next = ST_ACTIVE;
               w_start      = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!w_en || w_ss_rise) begin
               w_state_next = ST_IDLE;
               w_stop       = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // ------------------------------------------------------------------
   // SCLK edge roles; nothing shifts on the cycle the select ends.
   // ------------------------------------------------------------------
   assign w_act         = (r_state == ST_ACTIVE) && !w_stop;
   assign w_lead        = r_cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail       = r_cpol ? w_sclk_rise : w_sclk_fall;
   assign w_sample      = w_act && (r_cpha ? w_trail : w_lead);
   assign w_drive       = w_act && (r_cpha ? w_lead  : w_trail);
   assign w_byte_done   = w_sample && (r_bit_cnt == 3'd7);
   assign w_shift_in    = {r_shift[6:0], w_mosi};
   assign w_reload_byte = r_tx_full ? r_tx_buf : 8'h00;

   // ------------------------------------------------------------------
   // Register bus decode
   // ------------------------------------------------------------------
   assign w_rd      = i_en & ~i_wr;
   assign w_wr      = i_en &  i_wr;
   assign w_wr_dout = w_wr && (i_addr == c_ADDR_DATA_OUT);
   assign w_wr_stat = w_wr && (i_addr == c_ADDR_STATUS);
   assign w_wr_ctrl = w_wr && (i_addr == c_ADDR_CTRL);
   assign w_rd_din  = w_rd && (i_addr == c_ADDR_DATA_IN);

   always_comb begin
      w_rd_data = 8'h00;
      case (i_addr)
         c_ADDR_STATUS: begin
            w_rd_data[c_STAT_BUSY]     = w_busy;
            w_rd_data[c_STAT_RX_VALID] = r_rx_valid;
            w_rd_data[c_STAT_TX_FULL]  = r_tx_full;
            w_rd_data[c_STAT_OVERRUN]  = r_overrun;
         end
         c_ADDR_DATA_OUT: w_rd_data = r_tx_buf;
         c_ADDR_DATA_IN:  w_rd_data = r_rx_data;
         c_ADDR_CTRL:     w_rd_data = {5'b0, r_ctrl};
         default:         w_rd_data = 8'h00;
      endcase
   end

   // ------------------------------------------------------------------
   // CTRL and active mode
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ctrl <= 3'b000;
         r_cpol <= 1'b0;
         r_cpha <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_ctrl <= i_data[2:0];
         if (w_start) begin
            r_cpol <= r_ctrl[c_CTRL_CPOL];
            r_cpha <= r_ctrl[c_CTRL_CPHA];
         end
      end
   end

   // ------------------------------------------------------------------
   // TX buffer: a CPU write in the reload cycle lands after the reload
   // consumed the old contents, so tx_full ends set.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_buf  <= 8'h00;
         r_tx_full <= 1'b0;
      end else begin
         if (w_start || w_byte_done) r_tx_full <= 1'b0;
         if (w_wr_dout) begin
            r_tx_buf  <= i_data;
            r_tx_full <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Shift register, bit counter and MISO
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shift   <= 8'h00;
         r_bit_cnt <= 3'd0;
         r_miso    <= 1'b0;
         r_miso_oe <= 1'b0;
      end else begin
         if (w_start) begin
            r_shift   <= w_reload_byte;
            r_bit_cnt <= 3'd0;
            r_miso    <= w_reload_byte[7];
            r_miso_oe <= 1'b1;
         end else begin
            if (w_stop) r_miso_oe <= 1'b0;
            if (w_byte_done) begin
               r_shift   <= w_reload_byte;
               r_bit_cnt <= 3'd0;
            end else if (w_sample) begin
               r_shift   <= w_shift_in;
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            // After a sample the next outgoing bit sits in the MSB.
            if (w_drive) r_miso <= r_shift[7];
         end
      end
   end

   // ------------------------------------------------------------------
   // RX data and flags: byte completion wins over a read-clear, and an
   // overrun set wins over a clear in the same cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_rd_din) r_rx_valid <= 1'b0;
         if (w_wr_stat && i_data[c_STAT_OVERRUN]) r_overrun <= 1'b0;
         if (w_byte_done) begin
            r_rx_data  <= w_shift_in;
            r_rx_valid <= 1'b1;
            if (r_rx_valid) r_overrun <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered read data
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     r_data <= 8'h00;
      else if (w_rd) r_data <= w_rd_data;
   end

   assign o_data    = r_data;
   assign o_MISO    = r_miso;
   assign o_MISO_oe = r_miso_oe;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Purpose  : Self-checking bench for spi_slave. A bit-banged SPI master and
//             a CPU bus driver issue stimulus; a byte-level reference model
//             queues expected read data and MISO bytes; monitors compare.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave;
   import spi_slave_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_SCLK, i_MOSI, i_SS;
   logic       o_MISO, o_MISO_oe;
   logic       i_en, i_wr;
   logic [3:0] i_addr;
   logic [7:0] i_data;
   logic [7:0] o_data;

   always #5 i_clk = ~i_clk;

   spi_slave #(.CLK_FREQ(48_000_000), .SYNC_STAGES(2)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_SCLK   (i_SCLK),
      .i_MOSI   (i_MOSI),
      .o_MISO   (o_MISO),
      .o_MISO_oe(o_MISO_oe),
      .i_SS     (i_SS),
      .i_en     (i_en),
      .i_wr     (i_wr),
      .i_addr   (i_addr),
      .i_data   (i_data),
      .o_data   (o_data)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
   endtask

   // ---------------- reference model (byte / register level) -----------
   logic [2:0] m_ctrl;
   logic [7:0] m_tx_buf, m_rx_data, m_loaded;
   logic       m_tx_full, m_rx_valid, m_ovr, m_active, m_ss_low;
   logic       cur_cpol, cur_cpha;

   logic [7:0] exp_rd_q[$];
   string      rd_name_q[$];
   logic [7:0] exp_miso_q[$];
   logic [7:0] got_miso_q[$];

   task automatic model_reset();
      m_ctrl = 3'b0; m_tx_buf = 8'h00; m_rx_data = 8'h00; m_loaded = 8'h00;
      m_tx_full = 1'b0; m_rx_valid = 1'b0; m_ovr = 1'b0; m_active = 1'b0;
   endtask

   task automatic push_read(input logic [3:0] addr, input string name);
      logic [7:0] v;
      case (addr)
         4'd0:    v = {4'b0, m_ovr, m_tx_full, m_rx_valid, m_ctrl[2] & m_ss_low};
         4'd1:    v = m_tx_buf;
         4'd2:    begin v = m_rx_data; m_rx_valid = 1'b0; end
         4'd3:    v = {5'b0, m_ctrl};
         default: v = 8'h00;
      endcase
      exp_rd_q.push_back(v);
      rd_name_q.push_back(name);
   endtask

   // ---------------- CPU bus driver ------------------------------------
   task automatic cpu_write(input logic [3:0] addr, input logic [7:0] d);
      @(negedge i_clk);
      i_en = 1'b1; i_wr = 1'b1; i_addr = addr; i_data = d;
      case (addr)
         4'd0:    if (d[3]) m_ovr = 1'b0;
         4'd1:    begin m_tx_buf = d; m_tx_full = 1'b1; end
         4'd3:    m_ctrl = d[2:0];
         default: ;
      endcase
      @(negedge i_clk);
      i_en = 1'b0; i_wr = 1'b0;
   endtask

   task automatic cpu_read(input logic [3:0] addr, input string name);
      @(negedge i_clk);
      i_en = 1'b1; i_wr = 1'b0; i_addr = addr;
      push_read(addr, name);
      @(negedge i_clk);
      i_en = 1'b0;
   endtask

   // ---------------- SPI master (half period = 4 system clocks) --------
   task automatic spi_begin();
      cur_cpol = m_ctrl[1];
      cur_cpha = m_ctrl[0];
      i_SCLK   = cur_cpol;
      repeat (4) @(negedge i_clk);
      i_SS = 1'b0; m_ss_low = 1'b1;
      m_active = m_ctrl[2];
      if (m_active) begin
         m_loaded  = m_tx_full ? m_tx_buf : 8'h00;
         m_tx_full = 1'b0;
      end
      repeat (8) @(negedge i_clk);
      chk("miso_oe_on_select", {7'b0, o_MISO_oe}, {7'b0, m_active});
   endtask

   task automatic spi_end();
      i_SS = 1'b1; m_ss_low = 1'b0; m_active = 1'b0;
      repeat (8) @(negedge i_clk);
   endtask

   // A DATA_IN read timed to land on the same clock as the slave's
   // reaction to the pin edge just driven (three clocks of latency).
   task automatic collide_read();
      repeat (2) @(negedge i_clk);
      i_en = 1'b1; i_wr = 1'b0; i_addr = c_ADDR_DATA_IN;
      exp_rd_q.push_back(m_rx_data);
      rd_name_q.push_back("collide_rd_old");
      m_rx_valid = 1'b0;
      @(negedge i_clk);
      i_en = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic spi_byte(input logic [7:0] b, input int nbits, input bit collide);
      logic [7:0] got;
      got = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cur_cpha) begin
            i_MOSI = b[i];
            repeat (4) @(negedge i_clk);
            i_SCLK = ~cur_cpol; got[i] = o_MISO;
            if (collide && i == 0) collide_read();
            else repeat (4) @(negedge i_clk);
            i_SCLK = cur_cpol;
         end else begin
            repeat (4) @(negedge i_clk);
            i_SCLK = ~cur_cpol; i_MOSI = b[i];
            repeat (4) @(negedge i_clk);
            i_SCLK = cur_cpol; got[i] = o_MISO;
            if (collide && i == 0) collide_read();
         end
      end
      repeat (4) @(negedge i_clk);
      if (m_active && nbits == 8) begin
         exp_miso_q.push_back(m_loaded);
         got_miso_q.push_back(got);
         if (m_rx_valid) m_ovr = 1'b1;
         m_rx_data  = b;
         m_rx_valid = 1'b1;
         m_loaded   = m_tx_full ? m_tx_buf : 8'h00;
         m_tx_full  = 1'b0;
      end
   endtask

   // ---------------- monitors ------------------------------------------
   initial begin : mon_rd
      forever begin
         @(posedge i_clk);
         if (i_en === 1'b1 && i_wr === 1'b0) begin
            @(negedge i_clk);
            if (exp_rd_q.size() > 0) chk(rd_name_q.pop_front(), o_data, exp_rd_q.pop_front());
            else begin
               n_checks++;
               $display("FAIL rd_unexpected: got 0x%02h with no expected value", o_data);
            end
         end
      end
   end

   initial begin : mon_miso
      forever begin
         @(negedge i_clk);
         if (got_miso_q.size() > 0 && exp_miso_q.size() > 0)
            chk("master_rx_miso", got_miso_q.pop_front(), exp_miso_q.pop_front());
      end
   end

   // ---------------- stimulus ------------------------------------------
   initial begin : stim
      int nb;
      i_rst = 1'b1; i_SCLK = 1'b0; i_MOSI = 1'b0; i_SS = 1'b1;
      i_en = 1'b0; i_wr = 1'b0; i_addr = 4'd0; i_data = 8'h00;
      m_ss_low = 1'b0; cur_cpol = 1'b0; cur_cpha = 1'b0;
      model_reset();
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      chk("reset_o_data", o_data, 8'h00);
      chk("reset_miso", {7'b0, o_MISO}, 8'h00);
      chk("reset_miso_oe", {7'b0, o_MISO_oe}, 8'h00);
      cpu_read(c_ADDR_STATUS, "reset_status");
      cpu_read(c_ADDR_CTRL, "reset_ctrl");
      cpu_read(4'd9, "unknown_addr");

      // mode 0, DATA_OUT=A5, master sends 3C
      cpu_write(c_ADDR_CTRL, 8'h04);
      cpu_write(c_ADDR_DATA_OUT, 8'hA5);
      cpu_read(c_ADDR_DATA_OUT, "dout_readback");
      cpu_read(c_ADDR_STATUS, "status_tx_full");
      spi_begin();
      spi_byte(8'h3C, 8, 1'b0);
      cpu_read(c_ADDR_STATUS, "status_busy_rxv");
      cpu_read(c_ADDR_DATA_IN, "data_in_3c");
      cpu_read(c_ADDR_STATUS, "status_after_rd");
      spi_end();

      // modes 1..3
      for (int m = 1; m < 4; m++) begin
         cpu_write(c_ADDR_CTRL, 8'h04 | m[7:0]);
         cpu_write(c_ADDR_DATA_OUT, 8'h81);
         spi_begin();
         spi_byte(8'h7E, 8, 1'b0);
         spi_end();
         cpu_read(c_ADDR_DATA_IN, "data_in_mode");
      end

      // overrun
      cpu_write(c_ADDR_CTRL, 8'h04);
      spi_begin();
      spi_byte(8'h11, 8, 1'b0);
      spi_byte(8'h22, 8, 1'b0);
      spi_end();
      cpu_read(c_ADDR_STATUS, "status_overrun");
      cpu_read(c_ADDR_DATA_IN, "data_in_22");
      cpu_write(c_ADDR_STATUS, 8'h08);
      cpu_read(c_ADDR_STATUS, "status_ovr_cleared");

      // empty TX, partial byte, realignment
      spi_begin();
      spi_byte(8'h5A, 8, 1'b0);
      spi_end();
      cpu_read(c_ADDR_DATA_IN, "data_in_5a");
      spi_begin();
      spi_byte(8'hE7, 5, 1'b0);
      spi_end();
      cpu_read(c_ADDR_STATUS, "status_partial");
      spi_begin();
      spi_byte(8'hC3, 8, 1'b0);
      spi_end();
      cpu_read(c_ADDR_DATA_IN, "data_in_aligned");

      // DATA_IN read coinciding with byte completion
      spi_begin();
      spi_byte(8'h96, 8, 1'b1);
      spi_end();
      cpu_read(c_ADDR_STATUS, "status_after_collide");
      cpu_read(c_ADDR_DATA_IN, "data_in_96");

      // disabled: pins ignored
      cpu_write(c_ADDR_CTRL, 8'h00);
      cpu_write(c_ADDR_DATA_OUT, 8'h3E);
      spi_begin();
      spi_byte(8'hFF, 8, 1'b0);
      spi_end();
      cpu_read(c_ADDR_STATUS, "status_disabled");
      cpu_read(c_ADDR_DATA_IN, "data_in_disabled");

      // randomized transfers
      for (int it = 0; it < 24; it++) begin
         cpu_write(c_ADDR_CTRL, {5'b0, 1'b1, 2'($urandom_range(0, 3))});
         if ($urandom_range(0, 1) == 1) cpu_write(c_ADDR_DATA_OUT, 8'($urandom));
         if ($urandom_range(0, 3) == 0) cpu_write(c_ADDR_STATUS, 8'h08);
         spi_begin();
         nb = $urandom_range(1, 2);
         for (int k = 0; k < nb; k++) spi_byte(8'($urandom), 8, 1'b0);
         if ($urandom_range(0, 2) == 0) spi_byte(8'($urandom), $urandom_range(1, 7), 1'b0);
         if ($urandom_range(0, 1) == 1) cpu_read(c_ADDR_STATUS, "rnd_status_mid");
         spi_end();
         cpu_read(c_ADDR_STATUS, "rnd_status");
         cpu_read(4'($urandom_range(0, 15)), "rnd_reg");
         if ($urandom_range(0, 1) == 1) cpu_read(c_ADDR_DATA_IN, "rnd_data_in");
      end

      // asynchronous reset in the middle of a transfer
      cpu_write(c_ADDR_CTRL, 8'h04);
      cpu_write(c_ADDR_DATA_OUT, 8'hA5);
      cpu_read(c_ADDR_DATA_OUT, "pre_reset_dout");
      spi_begin();
      spi_byte(8'hF0, 4, 1'b0);
      #2 i_rst = 1'b1;
      #1;
      chk("async_rst_miso_oe", {7'b0, o_MISO_oe}, 8'h00);
      chk("async_rst_o_data", o_data, 8'h00);
      chk("async_rst_miso", {7'b0, o_MISO}, 8'h00);
      model_reset();
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      cpu_read(c_ADDR_STATUS, "post_rst_status");
      cpu_read(c_ADDR_DATA_OUT, "post_rst_dout");
      cpu_read(c_ADDR_DATA_IN, "post_rst_din");
      cpu_read(c_ADDR_CTRL, "post_rst_ctrl");
      i_SS = 1'b1; m_ss_low = 1'b0;

      // drain monitors with a bounded wait
      for (int k = 0; k < 50 && (exp_rd_q.size() > 0 || got_miso_q.size() > 0); k++)
         @(negedge i_clk);
      if (exp_rd_q.size() > 0 || got_miso_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d reads and %0d bytes still pending, required 0",
                  exp_rd_q.size(), got_miso_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (slave) endpoint with the same CPU-side register bus as the team's spi_master.
- Lets the FPGA act as the device on an external SPI bus, for example to be driven by a host MCU or by our own spi_master in loopback.
- Samples the external SCLK/MOSI/SS pins in the i_clk domain and shifts bytes MSB-first.
- Holds one TX buffer byte and one RX data byte, with status flags the CPU can poll.

Parameters:
- CLK_FREQ, 48_000_000, system clock frequency in Hz. Documentation only; SCLK must not exceed CLK_FREQ/8.
- SYNC_STAGES, 2, number of synchroniser flops on SCLK, MOSI and SS (minimum 2).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, asynchronous, active-high
- i_SCLK  input  1  SPI clock from the external master
- i_MOSI  input  1  master out, slave in
- o_MISO  output  1  master in, slave out
- o_MISO_oe  output  1  MISO output enable; 1 only while enabled and SS is active
- i_SS  input  1  slave select, active-low
- i_en  input  1  device enable (bus strobe)
- i_wr  input  1  {0: read, 1: write}
- i_addr  input  4  {0: STATUS, 1: DATA_OUT, 2: DATA_IN, 3: CTRL}
- i_data  input  8  write data
- o_data  output  8  last data read, registered

Behaviour:
- Reset (async, i_rst=1) values:
  - o_data=0, o_MISO=0, o_MISO_oe=0
  - CTRL=0, tx_buf=0, tx_full=0, rx_data=0, rx_valid=0, overrun=0
  - shift=0, bit_cnt=0, synchronisers cleared, SS sync flops preset to 1 (inactive)
- Register reads: o_data updates on the clock edge after i_en=1 with i_wr=0.
  - STATUS reads {4'b0, overrun, tx_full, rx_valid, busy}.
  - DATA_OUT reads tx_buf.
  - DATA_IN reads rx_data and clears rx_valid.
  - CTRL reads {5'b0, enable, CPOL, CPHA}.
  - Unknown addresses read 0.
- Register writes:
  - DATA_OUT: tx_buf <= i_data, tx_full <= 1. Overwrites the buffer if already full.
  - STATUS: writing bit3=1 clears overrun; all other bits are ignored.
  - CTRL: stores bits [2:0]. Mode bits are latched into the active mode only on an SS falling edge.
  - DATA_IN: writes are ignored.
- Pin sampling:
  - SCLK, MOSI and SS each pass through SYNC_STAGES flops.
  - SCLK edges and SS edges are detected from the last two synchronised samples.
  - Total pin-to-action latency is SYNC_STAGES+1 cycles.
- busy = enable & (synchronised SS == 0).
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on an SS falling edge while enable=1. Actions:
    - latch mode
    - bit_cnt <= 0
    - load shift <= tx_full ? tx_buf : 8'h00, then clear tx_full
    - o_MISO <= MSB of the loaded byte
  - ACTIVE -> IDLE on an SS rising edge, or when enable goes 0.
    - A partial byte is discarded; rx_valid is unchanged.
    - o_MISO_oe <= 0.
- Edge roles in ACTIVE:
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - CPHA=0: sample MOSI on the leading edge, shift out the next bit on the trailing edge.
  - CPHA=1: shift out on the leading edge, sample on the trailing edge.
  - With CPHA=1 the first MSB is driven on the first leading edge, not at SS fall.
- Byte completion on the 8th sample edge:
  - rx_data <= the assembled byte, rx_valid <= 1.
  - If rx_valid was already 1, overrun <= 1; the new byte still overwrites.
  - Reload shift from tx_buf (clears tx_full) or with 8'h00 if empty. bit_cnt wraps to 0.
- Simultaneous events:
  - Byte completion and a DATA_IN read in the same cycle: the read returns the old rx_data, and rx_valid ends at 1 (set wins).
  - Reload and a DATA_OUT write in the same cycle: the reload uses the old buffer state; the written byte lands in tx_buf and tx_full ends at 1.
  - Overrun set and overrun clear in the same cycle: set wins.
- enable=0: SPI pins are ignored and no state changes occur; the register bus still works.

Decomposition:
- Shared package holds:
  - register address localparams STATUS/DATA_OUT/DATA_IN/CTRL
  - STATUS bit indices
  - CTRL bit indices: CPHA=0, CPOL=1, EN=2
- These are shared with spi_master.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall pulse outputs, instantiated for SCLK, SS and MOSI (MOSI uses data output only).

Test Plan:
- Reset mid-transfer (SS low, 4 bits shifted, assert i_rst) -> all registers are 0 and o_MISO_oe=0 immediately, with no clock needed.
- Mode 0, CPU writes DATA_OUT=0xA5, master sends 0x3C at CLK_FREQ/8 -> MISO bits are 1,0,1,0,0,1,0,1. Afterwards STATUS=0x03 while SS is low, and DATA_IN read returns 0x3C, then STATUS=0x01.
- Modes 1, 2 and 3, each with DATA_OUT=0x81, master sends 0x7E -> master receives 0x81 and DATA_IN=0x7E in every mode.
- Two bytes 0x11 then 0x22 with no CPU read between -> overrun=1 and DATA_IN=0x22. Writing STATUS=0x08 clears overrun to 0.
- No DATA_OUT write, master clocks 1 byte -> MISO returns 0x00. SS deasserted after 5 bits -> rx_valid stays 0 and the next transfer is byte-aligned.
- DATA_IN read in the same cycle as the 8th sample edge -> o_data holds the old value and rx_valid=1 afterwards. CTRL enable=0 with SS toggling -> no status change.
